// File: rtl/des_pkg.sv
// Shared constants and state encoding for the DES key-schedule engine.
package des_pkg;

  localparam int DES_HALF_W = 28;
  localparam int DES_ROUNDS = 16;
  localparam logic [DES_ROUNDS-1:0] DES_SHIFT1_MASK = 16'h8103;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } des_state_t;

endpackage

// File: rtl/des_key_sched_key_rot.sv
// Combinational half-key rotator: rotates by 1 or 2 bits, left or right, modulo W.
module key_rot #(
  parameter int W = 28
) (
  input  logic [W-1:0] data,
  input  logic         fRight,
  input  logic         f1bit,
  output logic [W-1:0] rotated
);

  logic [W-1:0] rol1, rol2, ror1, ror2;

  assign rol1 = {data[W-2:0], data[W-1]};
  assign rol2 = {data[W-3:0], data[W-1:W-2]};
  assign ror1 = {data[0], data[W-1:1]};
  assign ror2 = {data[1:0], data[W-1:2]};

  always_comb begin
    rotated = rol2;
    if (fRight) rotated = f1bit ? ror1 : ror2;
    else        rotated = f1bit ? rol1 : rol2;
  end

endmodule

// File: rtl/des_key_sched.sv
// Sequential DES key schedule: loads post-PC1 {C,D}, emits N rotated round keys
// over a valid/ready handshake, one round per accepted transfer.
module des_key_sched
  import des_pkg::*;
#(
  parameter int               W           = DES_HALF_W,
  parameter int               N           = DES_ROUNDS,
  parameter logic [N-1:0]     SHIFT1_MASK = DES_SHIFT1_MASK,
  localparam int              RW          = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic          i_Start,
  input  logic          i_fDecrypt,
  input  logic [2*W-1:0] i_Key,
  input  logic          i_Ready,
  output logic          o_Valid,
  output logic [2*W-1:0] o_CD,
  output logic [RW-1:0] o_Round,
  output logic          o_Busy,
  output logic          o_Done
);

  des_state_t   state;
  logic         mode;
  logic [W-1:0] c, d;
  logic [RW-1:0] round;
  logic         done;

  logic [W-1:0] rot_in_c, rot_in_d, rot_c, rot_d;
  logic         rot_right;
  logic [RW-1:0] sh_idx;

  // In IDLE the rotators work on the incoming key so a start can load ROL(sh(0)) directly.
  always_comb begin
    rot_in_c  = c;
    rot_in_d  = d;
    rot_right = mode;
    sh_idx    = mode ? (RW'(N-1) - round) : (round + RW'(1));
    if (state == IDLE) begin
      rot_in_c  = i_Key[2*W-1:W];
      rot_in_d  = i_Key[W-1:0];
      rot_right = 1'b0;
      sh_idx    = '0;
    end
  end

  key_rot #(.W(W)) u_rot_c (
    .data    (rot_in_c),
    .fRight  (rot_right),
    .f1bit   (SHIFT1_MASK[sh_idx]),
    .rotated (rot_c)
  );

  key_rot #(.W(W)) u_rot_d (
    .data    (rot_in_d),
    .fRight  (rot_right),
    .f1bit   (SHIFT1_MASK[sh_idx]),
    .rotated (rot_d)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state <= IDLE;
      mode  <= 1'b0;
      c     <= '0;
      d     <= '0;
      round <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_Start) begin
            state <= RUN;
            mode  <= i_fDecrypt;
            round <= '0;
            // Decrypt round 0 is the loaded key itself.
            c     <= i_fDecrypt ? i_Key[2*W-1:W] : rot_c;
            d     <= i_fDecrypt ? i_Key[W-1:0]   : rot_d;
          end
        end
        RUN: begin
          if (i_Ready) begin
            if (round == RW'(N-1)) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              round <= round + RW'(1);
              c     <= rot_c;
              d     <= rot_d;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_Valid = (state == RUN);
  assign o_Busy  = (state == RUN);
  assign o_CD    = {c, d};
  assign o_Round = round;
  assign o_Done  = done;

endmodule

// File: tb/tb_des_key_sched.sv
// Directed bench for des_key_sched: default 28/16 instance plus an 8-bit/4-round instance.
module tb_des_key_sched;

  localparam logic [15:0] MASK = 16'h8103;
  localparam logic [55:0] K1 = {28'h0000001, 28'h8000000};
  localparam logic [55:0] K2 = {28'h9ABCDEF, 28'h1234567};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, fdec, ready;
  logic [55:0] key;
  logic        valid, busy, done;
  logic [55:0] cd;
  logic [3:0]  round;

  logic        s_start, s_ready, s_valid, s_busy, s_done;
  logic [15:0] s_key, s_cd;
  logic [1:0]  s_round;

  int checks = 0;
  int failures = 0;

  des_key_sched dut (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_fDecrypt(fdec), .i_Key(key),
    .i_Ready(ready), .o_Valid(valid), .o_CD(cd), .o_Round(round), .o_Busy(busy), .o_Done(done)
  );

  des_key_sched #(.W(8), .N(4), .SHIFT1_MASK(4'b1111)) dut_small (
    .i_Clk(clk), .i_Rst(rst), .i_Start(s_start), .i_fDecrypt(1'b0), .i_Key(s_key),
    .i_Ready(s_ready), .o_Valid(s_valid), .o_CD(s_cd), .o_Round(s_round), .o_Busy(s_busy),
    .o_Done(s_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] rol28(input logic [27:0] x, input int n);
    int m;
    m = n % 28;
    if (m == 0) return x;
    return (x << m) | (x >> (28 - m));
  endfunction

  // Encrypt round r key = loaded key rotated left by the cumulative shift through round r.
  function automatic logic [55:0] enc_key(input logic [55:0] k, input int r);
    int s;
    s = 0;
    for (int j = 0; j <= r; j++) s += MASK[j] ? 1 : 2;
    return {rol28(k[55:28], s), rol28(k[27:0], s)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_round(input string tag, input int r, input logic [55:0] exp);
    check($sformatf("%s_r%0d_valid", tag, r), {63'd0, valid}, 64'd1);
    check($sformatf("%s_r%0d_round", tag, r), {60'd0, round}, 64'(r));
    check($sformatf("%s_r%0d_cd", tag, r), {8'd0, cd}, {8'd0, exp});
  endtask

  task automatic do_start(input logic m, input logic [55:0] k);
    start = 1'b1;
    fdec  = m;
    key   = k;
    tick();
    start = 1'b0;
  endtask

  task automatic check_done(input string tag, input logic [55:0] last);
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    check({tag, "_valid_lo"}, {63'd0, valid}, 64'd0);
    check({tag, "_busy_lo"}, {63'd0, busy}, 64'd0);
    check({tag, "_cd_hold"}, {8'd0, cd}, {8'd0, last});
  endtask

  logic [15:0] small_exp [4];

  initial begin
    small_exp = '{16'h0302, 16'h0604, 16'h0C08, 16'h1810};
    rst = 1'b1; start = 1'b0; fdec = 1'b0; ready = 1'b1; key = '0;
    s_start = 1'b0; s_ready = 1'b1; s_key = 16'h8101;
    repeat (2) tick();
    check("rst_valid", {63'd0, valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_cd", {8'd0, cd}, 64'd0);
    check("rst_round", {60'd0, round}, 64'd0);
    rst = 1'b0;
    tick();

    // Small parametrised instance
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("small_r%0d_cd", k), {48'd0, s_cd}, {48'd0, small_exp[k]});
      check($sformatf("small_r%0d_round", k), {62'd0, s_round}, 64'(k));
      check($sformatf("small_r%0d_valid", k), {63'd0, s_valid}, 64'd1);
      tick();
    end
    check("small_done", {63'd0, s_done}, 64'd1);
    check("small_valid_lo", {63'd0, s_valid}, 64'd0);

    // Encrypt, free-running
    do_start(1'b0, K1);
    for (int k = 0; k < 16; k++) begin
      check_round("enc", k, enc_key(K1, k));
      if (k == 0)  check("enc_hand0", {8'd0, cd}, {8'd0, 28'h0000002, 28'h0000001});
      if (k == 1)  check("enc_hand1", {8'd0, cd}, {8'd0, 28'h0000004, 28'h0000002});
      if (k == 2)  check("enc_hand2", {8'd0, cd}, {8'd0, 28'h0000010, 28'h0000008});
      if (k == 15) check("enc_hand15", {8'd0, cd}, {8'd0, 28'h0000001, 28'h8000000});
      check("enc_no_early_done", {63'd0, done}, 64'd0);
      tick();
    end
    check_done("enc", K1);
    tick();
    check("enc_done_pulse", {63'd0, done}, 64'd0);

    // Decrypt: reverse order of encrypt keys
    do_start(1'b1, K1);
    for (int k = 0; k < 16; k++) begin
      check_round("dec", k, enc_key(K1, 15 - k));
      if (k == 0) check("dec_hand0", {8'd0, cd}, {8'd0, 28'h0000001, 28'h8000000});
      if (k == 1) check("dec_hand1", {8'd0, cd}, {8'd0, 28'h8000000, 28'h4000000});
      if (k == 2) check("dec_hand2", {8'd0, cd}, {8'd0, 28'h2000000, 28'h1000000});
      tick();
    end
    check_done("dec", enc_key(K1, 0));
    tick();

    // Backpressure at round 3, ignored start at round 7
    do_start(1'b0, K1);
    for (int k = 0; k < 16; k++) begin
      check_round("bp", k, enc_key(K1, k));
      if (k == 3) begin
        ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          check_round("stall", 3, enc_key(K1, 3));
        end
        ready = 1'b1;
      end
      if (k == 7) begin
        start = 1'b1;
        fdec  = 1'b1;
        key   = K2;
      end
      tick();
      start = 1'b0;
    end
    check_done("bp", K1);

    // Start in the done cycle, then reset mid-schedule
    do_start(1'b1, K2);
    check_round("restart", 0, K2);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check_round("dec2", k, enc_key(K2, 15 - k));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", {63'd0, valid}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_cd", {8'd0, cd}, 64'd0);
    check("midrst_round", {60'd0, round}, 64'd0);
    for (int s = 0; s < 3; s++) begin
      tick();
      check($sformatf("midrst_no_done%0d", s), {63'd0, done}, 64'd0);
    end

    do_start(1'b0, K1);
    for (int k = 0; k < 16; k++) begin
      check_round("fresh", k, enc_key(K1, k));
      tick();
    end
    check_done("fresh", K1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/des_key_sched.md
Name: des_key_sched

Overview:
- Sequential DES-style key-schedule engine, parametrised in half-width and round count.
- Loads a post-PC1 key (C||D), then steps through N rounds.
- Each round rotates both halves left (encrypt) or right (decrypt) by 1 or 2 bits per a programmable schedule, and presents C||D with a valid/ready handshake.
- Sits between PC1 and PC2 in the cipher datapath. It is the registered, schedule-driven successor to the plain combinational half-key rotator.

Parameters:
- W, 28, half-key width in bits (C and D each W bits).
- N, 16, number of rounds.
- SHIFT1_MASK, 16'h8103, N-bit mask. Bit k=1 means encrypt round k (0-based) rotates by 1; bit k=0 means it rotates by 2.

Ports:
- i_Clk  in  1  clock, rising edge.
- i_Rst  in  1  synchronous reset, active-high.
- i_Start  in  1  start request. Accepted only when o_Busy=0.
- i_fDecrypt  in  1  mode, sampled at start. 0 = encrypt (ROL), 1 = decrypt (ROR).
- i_Key  in  2W  post-PC1 key {C,D}, sampled at start.
- i_Ready  in  1  downstream accepts current round output.
- o_Valid  out  1  o_CD/o_Round hold a valid round key.
- o_CD  out  2W  current rotated {C,D}.
- o_Round  out  clog2(N)  current round index, 0..N-1.
- o_Busy  out  1  schedule in progress.
- o_Done  out  1  one-cycle pulse after the final round is accepted.

Behaviour:
- Interface: one clock, i_Clk; reset i_Rst is synchronous and active-high.
- Reset: all outputs 0, state IDLE, mode 0, C/D 0. Reset overrides everything, including mid-schedule; any in-flight schedule is abandoned with no o_Done.
- FSM states:
  - IDLE: o_Busy=0, o_Valid=0.
  - RUN: o_Busy=1, o_Valid=1.
- Shift amount sh(k) = SHIFT1_MASK[k] ? 1 : 2.
- Start (IDLE and i_Start=1):
  - Next cycle: state RUN, o_Round=0, mode latched.
  - Encrypt: C,D = ROL(sh(0)) of the i_Key halves.
  - Decrypt: C,D = i_Key halves unrotated.
  - Latency from start to first valid: 1 cycle.
- Advance (RUN, o_Valid and i_Ready both 1), when o_Round < N-1:
  - o_Round increments to r+1.
  - Encrypt: rotate left by sh(r+1).
  - Decrypt: rotate right by sh(N-(r+1)).
- Stall: RUN with i_Ready=0 holds o_CD and o_Round stable; o_Valid stays 1.
- Final (RUN, o_Round=N-1, i_Ready=1):
  - Next cycle: IDLE, o_Valid=0, o_Busy=0, o_Done=1 for exactly one cycle.
  - o_CD keeps its last value.
- i_Start while o_Busy=1 is ignored, with no effect on mode/key.
- i_Start in the o_Done cycle is accepted, since state is IDLE then.
- Rotation: each half rotates independently within W bits, wrap-around modulo W. No carry between C and D.
- With the default mask the total encrypt rotation is 28 = W, so after round N-1 the halves equal the loaded key. Decrypt round r key equals encrypt round N-1-r key.
- All outputs are registered. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package des_pkg:
  - DES_HALF_W=28, DES_ROUNDS=16, DES_SHIFT1_MASK=16'h8103.
  - State enum {IDLE, RUN}.
- Sub-module key_rot: combinational, parametrised W. Inputs: data[W-1:0], fRight, f1bit. Output: data rotated by 1 or 2 in the given direction. Instantiate twice, once for C and once for D.

Test Plan:
- Encrypt, C=28'h0000001, D=28'h8000000, i_Ready=1 -> round0 {0000002,0000001}; round1 {0000004,0000002}; round2 {0000010,0000008}; round15 {0000001,8000000}; o_Done one cycle after round 15.
- Decrypt, same key -> round0 {0000001,8000000}; round1 {8000000,4000000}; round2 {2000000,1000000}; 16 round keys equal the encrypt keys in reverse order.
- Backpressure: i_Ready=0 for 5 cycles at round 3 -> o_Round=3 and o_CD stable, o_Valid=1; resumes at round 4 on release.
- i_Start with a new key at round 7 -> ignored; sequence completes with the original key. A start in the o_Done cycle -> accepted, new round0 valid next cycle.
- i_Rst asserted at round 9 -> next cycle all outputs 0, no o_Done; a fresh start afterwards runs a full 16 rounds.
- Parametrised instance W=8, N=4, SHIFT1_MASK=4'b1111, key {8'h81,8'h01} encrypt -> rounds {03,02},{06,04},{0C,08},{18,10}.
